// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX stage: ALUOp and funct codes, ALU control
// codes, and bit positions inside the wb/mem/ex control bundles.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_ctrl_e;

  // wb bundle {RegWrite, MemtoReg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;
  // mem bundle {Branch, MemRead, MemWrite}
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;
  // ex bundle {RegDst, ALUSrc, ALUOp[1:0]}
  localparam int EX_REG_DST   = 3;
  localparam int EX_ALU_SRC   = 2;
  localparam int EX_ALU_OP_HI = 1;
  localparam int EX_ALU_OP_LO = 0;

endpackage

// File: rtl/execute_if.sv
// ID/EX bundle, forwarding sources, stall/flush control and EX/MEM results
// exchanged between the execute stage and the surrounding pipeline.
interface execute_if;
  import mips_pkg::*;

  logic [1:0]        id_ex_wb;
  logic [2:0]        id_ex_mem;
  logic [3:0]        id_ex_execute;
  logic [DATA_W-1:0] id_ex_npc;
  logic [DATA_W-1:0] id_ex_readdat1;
  logic [DATA_W-1:0] id_ex_readdat2;
  logic [DATA_W-1:0] id_ex_sign_ext;
  logic [5:0]        id_ex_funct;
  logic [REG_W-1:0]  id_ex_rs;
  logic [REG_W-1:0]  id_ex_instr_bits_20_16;
  logic [REG_W-1:0]  id_ex_instr_bits_15_11;

  logic              fwd_mem_reg_write;
  logic [REG_W-1:0]  fwd_mem_reg;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              fwd_wb_reg_write;
  logic [REG_W-1:0]  fwd_wb_reg;
  logic [DATA_W-1:0] fwd_wb_data;

  logic              ex_stall;
  logic              ex_flush;

  logic [1:0]        ex_mem_wb;
  logic [2:0]        ex_mem_mem;
  logic [DATA_W-1:0] ex_mem_branch_target;
  logic              ex_mem_zero;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic [DATA_W-1:0] ex_mem_write_data;
  logic [REG_W-1:0]  ex_mem_write_reg;

  modport master (
    output id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
           id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext, id_ex_funct,
           id_ex_rs, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
           fwd_mem_reg_write, fwd_mem_reg, fwd_mem_data,
           fwd_wb_reg_write, fwd_wb_reg, fwd_wb_data,
           ex_stall, ex_flush,
    input  ex_mem_wb, ex_mem_mem, ex_mem_branch_target, ex_mem_zero,
           ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg
  );

  modport slave (
    input  id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
           id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext, id_ex_funct,
           id_ex_rs, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
           fwd_mem_reg_write, fwd_mem_reg, fwd_mem_data,
           fwd_wb_reg_write, fwd_wb_reg, fwd_wb_data,
           ex_stall, ex_flush,
    output ex_mem_wb, ex_mem_mem, ex_mem_branch_target, ex_mem_zero,
           ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU: decodes ALUOp/funct into an ALU control code, performs
// the operation (wrapping arithmetic, signed slt) and raises zero.
module alu
  import mips_pkg::*;
(
  input  logic [1:0]               alu_op,
  input  logic [5:0]               funct,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic [DATA_W-1:0]        result,
  output logic                     zero
);

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl = ALU_NOP;
    case (alu_op)
      ALUOP_ADD, ALUOP_ADDI: ctrl = ALU_ADD;
      ALUOP_SUB:             ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          default:   ctrl = ALU_NOP;
        endcase
      end
      default: ctrl = ALU_NOP;
    endcase
  end

  // Unrecognised R-type functs produce 0 rather than trapping.
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = (a < b) ? 32'h1 : 32'h0;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// MIPS execute stage: operand forwarding, ALU, branch target and destination
// select, registered into EX/MEM with stall (hold) and flush (bubble).
module execute
  import mips_pkg::*;
(
  input logic      clk,
  input logic      rst,
  execute_if.slave io
);

  // Register 0 never forwards; EX/MEM wins over MEM/WB.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] rf_val,
    input logic              mem_we,
    input logic [REG_W-1:0]  mem_reg,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_reg,
    input logic [DATA_W-1:0] wb_data
  );
    if (mem_we && (mem_reg != '0) && (mem_reg == src))
      return mem_data;
    else if (wb_we && (wb_reg != '0) && (wb_reg == src))
      return wb_data;
    else
      return rf_val;
  endfunction

  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] fwd_b_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic [DATA_W-1:0]        alu_result_p0;
  logic                     zero_p0;
  logic [DATA_W-1:0]        branch_target_p0;
  logic [REG_W-1:0]         write_reg_p0;

  // Stage p0: combinational execute
  assign op_a_p0 = fwd_sel(io.id_ex_rs, io.id_ex_readdat1,
                           io.fwd_mem_reg_write, io.fwd_mem_reg, io.fwd_mem_data,
                           io.fwd_wb_reg_write, io.fwd_wb_reg, io.fwd_wb_data);
  assign fwd_b_p0 = fwd_sel(io.id_ex_instr_bits_20_16, io.id_ex_readdat2,
                            io.fwd_mem_reg_write, io.fwd_mem_reg, io.fwd_mem_data,
                            io.fwd_wb_reg_write, io.fwd_wb_reg, io.fwd_wb_data);
  assign op_b_p0 = io.id_ex_execute[EX_ALU_SRC] ? io.id_ex_sign_ext : fwd_b_p0;

  assign branch_target_p0 = io.id_ex_npc + (io.id_ex_sign_ext << 2);
  assign write_reg_p0 = io.id_ex_execute[EX_REG_DST] ? io.id_ex_instr_bits_15_11
                                                     : io.id_ex_instr_bits_20_16;

  alu u_alu (
    .alu_op (io.id_ex_execute[EX_ALU_OP_HI:EX_ALU_OP_LO]),
    .funct  (io.id_ex_funct),
    .a      (op_a_p0),
    .b      (op_b_p0),
    .result (alu_result_p0),
    .zero   (zero_p0)
  );

  logic [1:0]        wb_p1;
  logic [2:0]        mem_p1;
  logic [DATA_W-1:0] branch_target_p1;
  logic              zero_p1;
  logic [DATA_W-1:0] alu_result_p1;
  logic [DATA_W-1:0] write_data_p1;
  logic [REG_W-1:0]  write_reg_p1;

  // Stage p1: EX/MEM register; data is cleared too so bubbles read as zero.
  always_ff @(posedge clk) begin
    if (rst || io.ex_flush) begin
      wb_p1            <= '0;
      mem_p1           <= '0;
      branch_target_p1 <= '0;
      zero_p1          <= 1'b0;
      alu_result_p1    <= '0;
      write_data_p1    <= '0;
      write_reg_p1     <= '0;
    end else if (!io.ex_stall) begin
      wb_p1            <= io.id_ex_wb;
      mem_p1           <= io.id_ex_mem;
      branch_target_p1 <= branch_target_p0;
      zero_p1          <= zero_p0;
      alu_result_p1    <= alu_result_p0;
      write_data_p1    <= fwd_b_p0;
      write_reg_p1     <= write_reg_p0;
    end
  end

  assign io.ex_mem_wb            = wb_p1;
  assign io.ex_mem_mem           = mem_p1;
  assign io.ex_mem_branch_target = branch_target_p1;
  assign io.ex_mem_zero          = zero_p1;
  assign io.ex_mem_alu_result    = alu_result_p1;
  assign io.ex_mem_write_data    = write_data_p1;
  assign io.ex_mem_write_reg     = write_reg_p1;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: expected EX/MEM bundles are queued
// when an instruction is driven and compared one edge later.
module tb_execute;

  logic clk;
  logic rst;

  execute_if bus ();

  execute dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] bt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
  } out_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } alu_vec_t;

  out_t exp_q[$];
  out_t got;
  out_t e;
  int   checks   = 0;
  int   failures = 0;

  function automatic out_t sample();
    return {bus.ex_mem_wb, bus.ex_mem_mem, bus.ex_mem_branch_target,
            bus.ex_mem_zero, bus.ex_mem_alu_result, bus.ex_mem_write_data,
            bus.ex_mem_write_reg};
  endfunction

  task automatic expect_out(input logic [1:0] wb, input logic [2:0] mem,
                            input logic [31:0] bt, input logic zero,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [4:0] wr);
    out_t o;
    o = {wb, mem, bt, zero, alu, wd, wr};
    exp_q.push_back(o);
  endtask

  task automatic idle_inputs();
    bus.id_ex_wb = '0;               bus.id_ex_mem = '0;
    bus.id_ex_execute = '0;          bus.id_ex_npc = '0;
    bus.id_ex_readdat1 = '0;         bus.id_ex_readdat2 = '0;
    bus.id_ex_sign_ext = '0;         bus.id_ex_funct = '0;
    bus.id_ex_rs = '0;               bus.id_ex_instr_bits_20_16 = '0;
    bus.id_ex_instr_bits_15_11 = '0;
    bus.fwd_mem_reg_write = 1'b0;    bus.fwd_mem_reg = '0;
    bus.fwd_mem_data = '0;           bus.fwd_wb_reg_write = 1'b0;
    bus.fwd_wb_reg = '0;             bus.fwd_wb_data = '0;
    bus.ex_stall = 1'b0;             bus.ex_flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_instr(input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    bus.id_ex_wb = 2'b10;
    bus.id_ex_execute = 4'b1010;
    bus.id_ex_funct = 6'b100000;
    bus.id_ex_rs = 5'd1;
    bus.id_ex_instr_bits_20_16 = 5'd2;
    bus.id_ex_instr_bits_15_11 = 5'd7;
    bus.id_ex_readdat1 = a;
    bus.id_ex_readdat2 = b;
  endtask

  task automatic test_reset();
    add_instr(32'd11, 32'd22);
    bus.id_ex_mem = 3'b111;
    bus.id_ex_npc = 32'h1000;
    bus.id_ex_sign_ext = 32'h10;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_out(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
      step();
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype_add();
    idle_inputs();
    bus.id_ex_wb = 2'b10;
    bus.id_ex_execute = 4'b1010;
    bus.id_ex_funct = 6'b100000;
    bus.id_ex_readdat1 = 32'd5;
    bus.id_ex_readdat2 = 32'd7;
    bus.id_ex_rs = 5'd1;
    bus.id_ex_instr_bits_20_16 = 5'd2;
    bus.id_ex_instr_bits_15_11 = 5'd3;
    bus.id_ex_npc = 32'h40;
    expect_out(2'b10, 3'b000, 32'h40, 1'b0, 32'd12, 32'd7, 5'd3);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL rtype_add got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_beq();
    idle_inputs();
    bus.id_ex_mem = 3'b100;
    bus.id_ex_execute = 4'b0001;
    bus.id_ex_readdat1 = 32'd9;
    bus.id_ex_readdat2 = 32'd9;
    bus.id_ex_rs = 5'd1;
    bus.id_ex_instr_bits_20_16 = 5'd2;
    bus.id_ex_instr_bits_15_11 = 5'd3;
    bus.id_ex_npc = 32'h100;
    bus.id_ex_sign_ext = 32'h4;
    expect_out(2'b00, 3'b100, 32'h110, 1'b1, 32'h0, 32'd9, 5'd2);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL beq got=%h exp=%h", got, e);
    end
    // Negative offset wraps below npc.
    bus.id_ex_sign_ext = 32'hFFFF_FFFF;
    bus.id_ex_readdat2 = 32'd8;
    expect_out(2'b00, 3'b100, 32'hFC, 1'b0, 32'h1, 32'd8, 5'd2);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL beq_neg got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_forward_priority();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      bus.id_ex_wb = 2'b10;
      bus.id_ex_readdat1 = 32'd1;
      bus.id_ex_readdat2 = 32'd10;
      bus.id_ex_rs = 5'd4;
      bus.id_ex_instr_bits_20_16 = 5'd0;
      bus.fwd_wb_reg_write = 1'b1;  bus.fwd_wb_reg = 5'd4;  bus.fwd_wb_data = 32'd2;
      bus.fwd_mem_reg_write = 1'b1; bus.fwd_mem_reg = 5'd4; bus.fwd_mem_data = 32'd3;
      case (c)
        0: expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'd13, 32'd10, 5'd0);
        1: begin
          bus.id_ex_rs = 5'd0;
          bus.fwd_wb_reg = 5'd0;
          bus.fwd_mem_reg = 5'd0;
          expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'd11, 32'd10, 5'd0);
        end
        2: begin
          bus.fwd_mem_reg_write = 1'b0;
          expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'd12, 32'd10, 5'd0);
        end
        3: begin
          bus.id_ex_instr_bits_20_16 = 5'd6;
          bus.fwd_mem_reg = 5'd6;
          bus.fwd_mem_data = 32'h100;
          expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'h102, 32'h100, 5'd6);
        end
        default: begin
          bus.fwd_wb_reg_write = 1'b0;
          bus.fwd_mem_reg = 5'd5;
          expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'd11, 32'd10, 5'd0);
        end
      endcase
      step();
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL forward[%0d] got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_back_to_back_alu();
    alu_vec_t vec[14];
    vec = '{
      '{2'b10, 6'b100000, 32'd2,         32'd3,         32'd5},
      '{2'b10, 6'b100010, 32'd10,        32'd3,         32'd7},
      '{2'b10, 6'b100010, 32'd3,         32'd10,        32'hFFFF_FFF9},
      '{2'b10, 6'b100100, 32'hF0F0,      32'hFF00,      32'hF000},
      '{2'b10, 6'b100101, 32'hF0F0,      32'h0F00,      32'hFFF0},
      '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,         32'd1},
      '{2'b10, 6'b101010, 32'd1,         32'hFFFF_FFFF, 32'd0},
      '{2'b10, 6'b101010, 32'd3,         32'd5,         32'd1},
      '{2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000},
      '{2'b10, 6'b100010, 32'd5,         32'd5,         32'd0},
      '{2'b10, 6'b100111, 32'd1,         32'd2,         32'd0},
      '{2'b00, 6'b100010, 32'd4,         32'd6,         32'd10},
      '{2'b01, 6'b100000, 32'd9,         32'd4,         32'd5},
      '{2'b11, 6'b100010, 32'd1,         32'd1,         32'd2}
    };
    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      bus.id_ex_wb = 2'b10;
      bus.id_ex_execute = {2'b10, vec[i].op};
      bus.id_ex_funct = vec[i].fn;
      bus.id_ex_rs = 5'd1;
      bus.id_ex_instr_bits_20_16 = 5'd2;
      bus.id_ex_instr_bits_15_11 = 5'(i + 1);
      bus.id_ex_readdat1 = vec[i].a;
      bus.id_ex_readdat2 = vec[i].b;
      expect_out(2'b10, 3'b000, 32'h0, (vec[i].r == 32'h0), vec[i].r, vec[i].b, 5'(i + 1));
      step();
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL alu[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_stall_flush();
    out_t held;
    idle_inputs();
    bus.id_ex_wb = 2'b11;
    bus.id_ex_mem = 3'b010;
    bus.id_ex_execute = 4'b0100;
    bus.id_ex_readdat1 = 32'h20;
    bus.id_ex_readdat2 = 32'h55;
    bus.id_ex_sign_ext = 32'h8;
    bus.id_ex_rs = 5'd1;
    bus.id_ex_instr_bits_20_16 = 5'd5;
    bus.id_ex_instr_bits_15_11 = 5'd9;
    bus.id_ex_npc = 32'h200;
    expect_out(2'b11, 3'b010, 32'h220, 1'b0, 32'h28, 32'h55, 5'd5);
    held = {2'b11, 3'b010, 32'h220, 1'b0, 32'h28, 32'h55, 5'd5};
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL lw got=%h exp=%h", got, e);
    end
    add_instr(32'h999, 32'h1);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(held);
      step();
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, e);
      end
    end
    bus.ex_flush = 1'b1;
    expect_out(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL stall_flush got=%h exp=%h", got, e);
    end
    bus.ex_flush = 1'b0;
    bus.ex_stall = 1'b0;
    expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'h99A, 32'h1, 5'd7);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL after_flush got=%h exp=%h", got, e);
    end
    bus.ex_flush = 1'b1;
    expect_out(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL flush_only got=%h exp=%h", got, e);
    end
    bus.ex_flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    add_instr(32'd1, 32'd2);
    expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'd3, 32'd2, 5'd7);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL pre_stall got=%h exp=%h", got, e);
    end
    bus.ex_stall = 1'b1;
    rst = 1'b1;
    expect_out(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset_mid_stall got=%h exp=%h", got, e);
    end
    rst = 1'b0;
    add_instr(32'd4, 32'd4);
    expect_out(2'b10, 3'b000, 32'h0, 1'b0, 32'd8, 32'd4, 5'd7);
    step();
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL resume got=%h exp=%h", got, e);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_rtype_add();
    test_beq();
    test_forward_priority();
    test_back_to_back_alu();
    test_stall_flush();
    test_reset_mid_stall();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
